// File: rtl/pwl_remap_pipe.sv
// Three-stage piecewise-linear m1->m2 remapper with run-time loadable node/intercept/slope tables.
// Build option REMAP_SAT_EN: saturate the intercept+term sum to [0, 2^OUT_W-1] instead of wrapping.
module pwl_remap_pipe #(
    parameter int IN_W      = 16,
    parameter int OUT_W     = 16,
    parameter int PIECE_NUM = 42,
    parameter int ADDR_W    = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   m1,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  m2,
    output logic              oor,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_sel,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [IN_W-1:0]   cfg_data
);
    localparam int TW = IN_W + 4;
    localparam int SW = IN_W + 5;

    logic [IN_W-1:0] node_tab  [PIECE_NUM+1];
    logic [IN_W-1:0] icpt_tab  [PIECE_NUM];
    logic [4:0]      slope_tab [PIECE_NUM];

    // Handshake: a sample moves on valid&ready at either end. Every stage shifts
    // together whenever the output register is empty or being taken this cycle.
    logic adv;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= PIECE_NUM; i++) node_tab[i] <= '0;
            for (int i = 0; i < PIECE_NUM; i++) begin
                icpt_tab[i]  <= '0;
                slope_tab[i] <= '0;
            end
        end else if (cfg_we) begin
            case (cfg_sel)
                2'd0: if (int'(cfg_addr) <= PIECE_NUM) node_tab[cfg_addr] <= cfg_data;
                2'd1: if (int'(cfg_addr) < PIECE_NUM)  icpt_tab[cfg_addr] <= cfg_data;
                2'd2: if (int'(cfg_addr) < PIECE_NUM)  slope_tab[cfg_addr] <= cfg_data[4:0];
                default: ;
            endcase
        end
    end

    // Stage 1: range compares; scanning downwards leaves the lowest matching piece.
    logic [ADDR_W-1:0] k_sel;
    logic              hit;
    logic              below;
    always_comb begin
        k_sel = '0;
        hit   = 1'b0;
        for (int i = PIECE_NUM - 1; i >= 0; i--) begin
            if (node_tab[i] < m1 && m1 <= node_tab[i+1]) begin
                k_sel = ADDR_W'(i);
                hit   = 1'b1;
            end
        end
    end
    assign below = (m1 <= node_tab[0]);

    logic              s1_valid, s1_oor, s1_below;
    logic [IN_W-1:0]   s1_m1;
    logic [ADDR_W-1:0] s1_k;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_oor   <= 1'b0;
            s1_below <= 1'b0;
            s1_m1    <= '0;
            s1_k     <= '0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_oor   <= ~hit;
            s1_below <= below;
            s1_m1    <= m1;
            s1_k     <= k_sel;
        end
    end

    // Stage 2: table fetch and shift-slope term.
    logic [4:0]    slope_code;
    logic [TW-1:0] mag;
    logic [TW-1:0] term;
    always_comb begin
        slope_code = slope_tab[s1_k];
        mag  = slope_code[2] ? (TW'(s1_m1) << slope_code[1:0]) : (TW'(s1_m1) >> slope_code[1:0]);
        term = slope_code[4] ? '0 : (slope_code[3] ? -mag : mag);
    end

    logic            s2_valid, s2_oor, s2_below;
    logic [IN_W-1:0] s2_icpt;
    logic [TW-1:0]   s2_term;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_oor   <= 1'b0;
            s2_below <= 1'b0;
            s2_icpt  <= '0;
            s2_term  <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            s2_oor   <= s1_oor;
            s2_below <= s1_below;
            s2_icpt  <= icpt_tab[s1_k];
            s2_term  <= term;
        end
    end

    // Stage 3: intercept is unsigned, term is signed; add at SW bits then reduce.
    logic [OUT_W-1:0] m2_next;
`ifdef REMAP_SAT_EN
    localparam int CW = (SW > OUT_W + 1) ? SW : OUT_W + 1;
    logic signed [SW-1:0] sum;
    logic signed [CW-1:0] sum_c;
    logic signed [CW-1:0] max_c;
    always_comb begin
        sum   = $signed(SW'(s2_icpt)) + $signed({s2_term[TW-1], s2_term});
        sum_c = CW'(sum);
        max_c = $signed({{(CW-OUT_W){1'b0}}, {OUT_W{1'b1}}});
        if (sum_c < 0)          m2_next = '0;
        else if (sum_c > max_c) m2_next = '1;
        else                    m2_next = OUT_W'(sum_c);
    end
`else
    always_comb begin
        m2_next = OUT_W'($signed(SW'(s2_icpt)) + $signed({s2_term[TW-1], s2_term}));
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            m2        <= '0;
            oor       <= 1'b0;
        end else if (adv) begin
            out_valid <= s2_valid;
            oor       <= s2_oor;
            m2        <= s2_oor ? (s2_below ? '0 : '1) : m2_next;
        end
    end
endmodule

// File: tb/tb_pwl_remap_pipe.sv
// Scoreboard bench for pwl_remap_pipe: directed table cases, streaming, backpressure, reset, random.
module tb_pwl_remap_pipe;
    localparam int IN_W = 16;
    localparam int OUT_W = 16;
    localparam int PIECE_NUM = 42;
    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   m1;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  m2;
    logic              oor;
    logic              cfg_we;
    logic [1:0]        cfg_sel;
    logic [ADDR_W-1:0] cfg_addr;
    logic [IN_W-1:0]   cfg_data;

    pwl_remap_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .PIECE_NUM(PIECE_NUM), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .m1(m1),
        .out_valid(out_valid), .out_ready(out_ready), .m2(m2), .oor(oor),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;
    logic [OUT_W:0] exp_q[$];
    int lat_q[$];
    logic [IN_W-1:0] sh_node [PIECE_NUM+1];
    logic [IN_W-1:0] sh_icpt [PIECE_NUM];
    logic [4:0]      sh_slope[PIECE_NUM];
    logic chk_lat = 1'b0;
    logic have_prev = 1'b0;
    int prev_edge = 0;
    int n_out = 0;
    logic rand_rdy = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [OUT_W:0] model(input logic [IN_W-1:0] v);
        longint t, s;
        logic [4:0] sc;
        for (int k = 0; k < PIECE_NUM; k++) begin
            if (sh_node[k] < v && v <= sh_node[k+1]) begin
                sc = sh_slope[k];
                if (sc[4]) t = 0;
                else begin
                    t = sc[2] ? (longint'(v) << sc[1:0]) : (longint'(v) >> sc[1:0]);
                    if (sc[3]) t = -t;
                end
                s = longint'(sh_icpt[k]) + t;
`ifdef REMAP_SAT_EN
                if (s < 0) return {1'b0, 16'h0000};
                if (s > 65535) return {1'b0, 16'hFFFF};
`endif
                return {1'b0, s[15:0]};
            end
        end
        return (v <= sh_node[0]) ? {1'b1, 16'h0000} : {1'b1, 16'hFFFF};
    endfunction

    task automatic clear_model();
        for (int i = 0; i <= PIECE_NUM; i++) sh_node[i] = '0;
        for (int i = 0; i < PIECE_NUM; i++) begin
            sh_icpt[i] = '0;
            sh_slope[i] = '0;
        end
    endtask

    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic cfg_write(input logic [1:0] sel, input int addr, input logic [15:0] data);
        cfg_we = 1'b1; cfg_sel = sel; cfg_addr = ADDR_W'(addr); cfg_data = data;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        case (sel)
            2'd0: if (addr <= PIECE_NUM) sh_node[addr] = data;
            2'd1: if (addr < PIECE_NUM) sh_icpt[addr] = data;
            2'd2: if (addr < PIECE_NUM) sh_slope[addr] = data[4:0];
            default: ;
        endcase
    endtask

    task automatic send_exp(input logic [IN_W-1:0] v, input logic [OUT_W:0] e);
        bit done = 0;
        m1 = v; in_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                lat_q.push_back(cyc + 1);
                done = 1;
            end
            @(posedge clk); #1;
        end
        if (!done) check("send_timeout", 0, 1);
    endtask

    task automatic send(input logic [IN_W-1:0] v);
        send_exp(v, model(v));
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done = 0;
        for (int i = 0; i < 500 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) done = 1;
        end
        if (!done) check("drain_timeout", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        logic [OUT_W:0] e;
        int a;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("stray_output", {31'b0, out_valid}, 0);
            else begin
                e = exp_q.pop_front();
                a = lat_q.pop_front();
                check("m2", m2, e[OUT_W-1:0]);
                check("oor", oor, e[OUT_W]);
                n_out++;
                if (chk_lat) begin
                    check("latency", cyc + 1 - a, 3);
                    if (have_prev) check("gap", cyc + 1 - prev_edge, 1);
                    have_prev = 1'b1;
                    prev_edge = cyc + 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IN_W-1:0] stall_v[4];
        logic [OUT_W-1:0] hold_m2;
        logic hold_oor;
        int acc, n0;
        bit seen;

        rst = 1'b1; in_valid = 1'b0; m1 = '0; out_ready = 1'b1;
        cfg_we = 1'b0; cfg_sel = '0; cfg_addr = '0; cfg_data = '0;
        clear_model();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_m2", m2, 0);
        check("rst_oor", oor, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Directed table; piece 41 also spans (0,0x1000] to exercise lowest-k priority.
        cfg_write(2'd0, 0, 16'h0000);
        cfg_write(2'd0, 1, 16'h1000);
        cfg_write(2'd0, PIECE_NUM, 16'h1000);
        cfg_write(2'd1, 0, 16'h0100);
        cfg_write(2'd2, 0, 16'h0002);
        cfg_write(2'd1, 41, 16'h7777);
        cfg_write(2'd2, 41, 16'h0010);
        cfg_write(2'd3, 0, 16'hFFFF);
        cfg_write(2'd0, 63, 16'hFFFF);
        cfg_write(2'd1, 42, 16'hFFFF);
        send_exp(16'h0800, {1'b0, 16'h0300});
        send_exp(16'h0000, {1'b1, 16'h0000});
        send_exp(16'hFFFF, {1'b1, 16'hFFFF});
        send_exp(16'h1000, {1'b0, 16'h0500});
        send_exp(16'h0001, {1'b0, 16'h0100});
        send_exp(16'h1001, {1'b1, 16'hFFFF});
        idle();
        wait_drain();

        cfg_write(2'd1, 0, 16'h0010);
        cfg_write(2'd2, 0, 16'h000E);
`ifdef REMAP_SAT_EN
        send_exp(16'h0100, {1'b0, 16'h0000});
`else
        send_exp(16'h0100, {1'b0, 16'hFC10});
`endif
        idle();
        wait_drain();

        // Back-to-back stream with the consumer always ready.
        cfg_write(2'd1, 0, 16'h0100);
        cfg_write(2'd2, 0, 16'h0005);
        chk_lat = 1'b1; have_prev = 1'b0; n0 = n_out;
        for (int i = 0; i < 10; i++) send(IN_W'(i * 16'h01C0));
        idle();
        wait_drain();
        chk_lat = 1'b0;
        check("stream_count", n_out - n0, 10);

        // Backpressure: consumer stalls while the producer keeps offering.
        stall_v[0] = 16'h0200; stall_v[1] = 16'h0400; stall_v[2] = 16'h0600; stall_v[3] = 16'h0800;
        out_ready = 1'b0; in_valid = 1'b1; acc = 0; m1 = stall_v[0];
        repeat (6) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(model(m1));
                lat_q.push_back(cyc + 1);
                acc++;
            end
            @(posedge clk); #1;
            if (acc < 4) m1 = stall_v[acc];
        end
        check("stall_accepts", acc, 3);
        @(negedge clk);
        check("stall_in_ready", in_ready, 0);
        hold_m2 = m2; hold_oor = oor;
        @(posedge clk); #1;
        idle();
        repeat (2) begin
            @(negedge clk);
            check("stall_valid", out_valid, 1);
            check("stall_m2_hold", m2, hold_m2);
            check("stall_oor_hold", oor, hold_oor);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_drain();

        // Reset with two samples in flight, head sample presented but not taken.
        out_ready = 1'b0;
        send(16'h0300);
        send(16'h0500);
        idle();
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        if (!seen) check("inflight_timeout", 0, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_m2", m2, 0);
        check("mid_rst_oor", oor, 0);
        exp_q.delete();
        lat_q.delete();
        clear_model();
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        send_exp(16'h0000, {1'b1, 16'h0000});
        send_exp(16'h1234, {1'b1, 16'hFFFF});
        idle();
        wait_drain();
        repeat (6) @(posedge clk);
        #1;

        // Random monotonic tables, random samples, random consumer stalls.
        for (int k = 0; k <= PIECE_NUM; k++)
            cfg_write(2'd0, k, 16'(k * 1500 + $urandom_range(0, 1000)));
        for (int k = 0; k < PIECE_NUM; k++) begin
            cfg_write(2'd1, k, 16'($urandom_range(0, 65535)));
            cfg_write(2'd2, k, 16'($urandom_range(0, 31)));
        end
        rand_rdy = 1'b1;
        for (int i = 0; i < 80; i++) send(16'($urandom_range(0, 65535)));
        idle();
        rand_rdy = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_drain();
        repeat (5) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
